// File: rtl/cpu_types_pkg.sv
// Shared CPU bus types and the memory arbiter state encoding.
package cpu_types_pkg;

    // Every address and data bus in the memory hierarchy is one 32-bit word.
    typedef logic [31:0] word_t;

    // Arbiter FSM states. The encoding is also driven on the arbiter's
    // debug port, so do not renumber these values.
    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_DGRANT = 2'd1,
        ARB_IGRANT = 2'd2
    } arb_state_t;

    // Default count of consecutive data grants a pending fetch will tolerate.
    localparam int ARB_STARVE_LIMIT = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Memory arbiter: shares the single RAM port between instruction fetch and
// data access. Data requests win by default. A saturating starvation counter
// forces a fetch grant once STARVE_LIMIT data accesses have completed while a
// fetch was waiting.
//
// Handshake: each requester holds its request (and address/data) asserted
// until it sees its wait output low for one cycle. That cycle is the
// completion beat, and load data is valid in that cycle. Only the granted side
// drives the RAM; the other side sees wait equal to its own request. Dropping a
// request before ramready aborts the access. The RAM strobes fall in the same
// cycle, and the FSM returns to idle.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int STARVE_LIMIT = ARB_STARVE_LIMIT
) (
    input  logic       CLK,
    input  logic       RST,
    // instruction fetch side
    input  logic       iREN,
    input  word_t      iaddr,
    output word_t      iload,
    output logic       iwait,
    // data side
    input  logic       dREN,
    input  logic       dWEN,
    input  word_t      daddr,
    input  word_t      dstore,
    output word_t      dload,
    output logic       dwait,
    // RAM port
    output logic       ramREN,
    output logic       ramWEN,
    output word_t      ramaddr,
    output word_t      ramstore,
    input  word_t      ramload,
    input  logic       ramready,
    // debug
    output logic [1:0] arb_state
);

    localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    arb_state_t       state, next_state;
    logic [CNT_W-1:0] starve_cnt, next_starve_cnt;

    logic dreq;
    logic d_active, i_active;
    logic d_done, i_done;

    assign dreq = dREN | dWEN;

    // A grant is "active" only while its requester still holds the request.
    // A dropped request is therefore an abort without any extra state.
    assign d_active = (state == ARB_DGRANT) && dreq;
    assign i_active = (state == ARB_IGRANT) && iREN;
    assign d_done   = d_active && ramready;
    assign i_done   = i_active && ramready;

    assign arb_state = state;

    // State and starvation counter registers. Reset drops any in-flight access.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= ARB_IDLE;
            starve_cnt <= '0;
        end else begin
            state      <= next_state;
            starve_cnt <= next_starve_cnt;
        end
    end

    // Next-state decision. Completion and abort both return to idle, which
    // leaves one bubble cycle between accesses.
    always_comb begin
        next_state = state;
        unique case (state)
            ARB_IDLE: begin
                if (dreq && (!iREN || (starve_cnt < LIMIT_C))) begin
                    next_state = ARB_DGRANT;
                end else if (iREN) begin
                    next_state = ARB_IGRANT;
                end
            end
            ARB_DGRANT: begin
                if (!dreq || ramready) begin
                    next_state = ARB_IDLE;
                end
            end
            ARB_IGRANT: begin
                if (!iREN || ramready) begin
                    next_state = ARB_IDLE;
                end
            end
            default: next_state = ARB_IDLE;
        endcase
    end

    // Starvation counter: counts data completions made while a fetch waited.
    // It saturates at the limit and clears on any completion that leaves no
    // fetch waiting. Aborts leave it untouched.
    always_comb begin
        next_starve_cnt = starve_cnt;
        if (d_done) begin
            if (iREN) begin
                if (starve_cnt < LIMIT_C) begin
                    next_starve_cnt = starve_cnt + 1'b1;
                end
            end else begin
                next_starve_cnt = '0;
            end
        end else if (i_done) begin
            next_starve_cnt = '0;
        end
    end

    // RAM port and requester outputs. These are combinational from state and
    // the live requests. Write wins over read when the data side asserts both.
    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iload    = '0;
        dload    = '0;
        iwait    = iREN;
        dwait    = dreq;
        if (d_active) begin
            ramaddr  = daddr;
            ramstore = dstore;
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            dload    = ramload;
            dwait    = ~ramready;
        end else if (i_active) begin
            ramaddr  = iaddr;
            ramREN   = 1'b1;
            iload    = ramload;
            iwait    = ~ramready;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter. It walks through reset, a lone fetch,
// simultaneous requests, starvation, abort, idle ramready and write-wins.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       iREN = 1'b0;
    word_t      iaddr = '0;
    word_t      iload;
    logic       iwait;
    logic       dREN = 1'b0;
    logic       dWEN = 1'b0;
    word_t      daddr = '0;
    word_t      dstore = '0;
    word_t      dload;
    logic       dwait;
    logic       ramREN;
    logic       ramWEN;
    word_t      ramaddr;
    word_t      ramstore;
    word_t      ramload = '0;
    logic       ramready = 1'b0;
    logic [1:0] arb_state;

    int n_cmp = 0;
    int n_err = 0;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramready(ramready),
        .arb_state(arb_state)
    );

    // clock / reset
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // advance to just past the next active edge
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // ---- reset state ----
        step(); step();
        chk("rst_state", 32'(arb_state), 32'(ARB_IDLE));
        chk("rst_ramREN", 32'(ramREN), 0);
        chk("rst_ramaddr", ramaddr, 0);
        RST = 1'b0;
        step();

        // ---- reset mid-DGRANT ----
        dREN = 1'b1; daddr = 32'h10;
        step();
        chk("rd_state", 32'(arb_state), 32'(ARB_DGRANT));
        chk("rd_ramREN", 32'(ramREN), 1);
        chk("rd_ramaddr", ramaddr, 32'h10);
        RST = 1'b1;
        #1;
        chk("rmid_state", 32'(arb_state), 32'(ARB_IDLE));
        chk("rmid_ramREN", 32'(ramREN), 0);
        chk("rmid_dwait", 32'(dwait), 1);
        chk("rmid_cnt", 32'(dut.starve_cnt), 0);
        dREN = 1'b0;
        step();
        RST = 1'b0;
        step();

        // ---- lone fetch, ready on third grant cycle ----
        iREN = 1'b1; iaddr = 32'h40;
        #1;
        chk("lf_idle_iwait", 32'(iwait), 1);
        chk("lf_idle_ramREN", 32'(ramREN), 0);
        step();
        chk("lf_g1_state", 32'(arb_state), 32'(ARB_IGRANT));
        chk("lf_g1_ramREN", 32'(ramREN), 1);
        chk("lf_g1_ramaddr", ramaddr, 32'h40);
        chk("lf_g1_iwait", 32'(iwait), 1);
        step();
        chk("lf_g2_iwait", 32'(iwait), 1);
        step();
        ramready = 1'b1; ramload = 32'h8C010004;
        #1;
        chk("lf_g3_iwait", 32'(iwait), 0);
        chk("lf_g3_iload", iload, 32'h8C010004);
        chk("lf_g3_ramWEN", 32'(ramWEN), 0);
        step();
        iREN = 1'b0; ramready = 1'b0;
        #1;
        chk("lf_idle_next", 32'(arb_state), 32'(ARB_IDLE));

        // ---- simultaneous requests, counter 0: data wins ----
        iREN = 1'b1; iaddr = 32'h44; dREN = 1'b1; daddr = 32'h200;
        step();
        chk("sim_state", 32'(arb_state), 32'(ARB_DGRANT));
        chk("sim_ramaddr", ramaddr, 32'h200);
        chk("sim_iwait", 32'(iwait), 1);
        chk("sim_iload", iload, 0);
        ramready = 1'b1; ramload = 32'h12345678;
        #1;
        chk("sim_dwait", 32'(dwait), 0);
        chk("sim_dload", dload, 32'h12345678);
        chk("sim_iwait_done", 32'(iwait), 1);
        step();
        ramready = 1'b0; dREN = 1'b0;
        #1;
        chk("sim_cnt", 32'(dut.starve_cnt), 1);
        // the waiting fetch goes next and its completion clears the counter
        step();
        chk("sim_ig_state", 32'(arb_state), 32'(ARB_IGRANT));
        ramready = 1'b1; ramload = 32'hCAFE0001;
        #1;
        chk("sim_ig_iload", iload, 32'hCAFE0001);
        step();
        ramready = 1'b0;
        #1;
        chk("sim_ig_cnt", 32'(dut.starve_cnt), 0);

        // ---- starvation: four data writes, then fetch is forced ----
        dWEN = 1'b1;
        for (int k = 0; k < 4; k++) begin
            daddr = 32'h300 + 32'(k * 4); dstore = 32'hA0 + 32'(k);
            chk("stv_idle", 32'(arb_state), 32'(ARB_IDLE));
            step();
            chk("stv_dgrant", 32'(arb_state), 32'(ARB_DGRANT));
            chk("stv_ramWEN", 32'(ramWEN), 1);
            chk("stv_ramstore", ramstore, 32'hA0 + 32'(k));
            ramready = 1'b1;
            #1;
            chk("stv_dwait", 32'(dwait), 0);
            chk("stv_iwait", 32'(iwait), 1);
            step();
            ramready = 1'b0;
            #1;
            chk("stv_cnt", 32'(dut.starve_cnt), 32'(k + 1));
        end
        step();
        chk("stv_force_ig", 32'(arb_state), 32'(ARB_IGRANT));
        chk("stv_ig_ramWEN", 32'(ramWEN), 0);
        chk("stv_ig_ramREN", 32'(ramREN), 1);
        chk("stv_ig_ramaddr", ramaddr, 32'h44);
        chk("stv_ig_dwait", 32'(dwait), 1);
        ramready = 1'b1; ramload = 32'h0BADF00D;
        #1;
        chk("stv_ig_iload", iload, 32'h0BADF00D);
        step();
        ramready = 1'b0; dWEN = 1'b0; iREN = 1'b0;
        #1;
        chk("stv_cnt_clr", 32'(dut.starve_cnt), 0);
        chk("stv_back_idle", 32'(arb_state), 32'(ARB_IDLE));

        // ---- abort: counter 1, then data request drops mid-grant ----
        iREN = 1'b1; iaddr = 32'h48; dREN = 1'b1; daddr = 32'h500;
        step();
        ramready = 1'b1;
        step();
        ramready = 1'b0;
        #1;
        chk("ab_cnt_pre", 32'(dut.starve_cnt), 1);
        step();
        chk("ab_dgrant", 32'(arb_state), 32'(ARB_DGRANT));
        chk("ab_ramREN_on", 32'(ramREN), 1);
        dREN = 1'b0;
        #1;
        chk("ab_ramREN_off", 32'(ramREN), 0);
        chk("ab_ramaddr_off", ramaddr, 0);
        step();
        iREN = 1'b0;
        #1;
        chk("ab_idle", 32'(arb_state), 32'(ARB_IDLE));
        chk("ab_cnt_keep", 32'(dut.starve_cnt), 1);

        // ---- ramready in idle is ignored ----
        ramready = 1'b1;
        #1;
        chk("idr_ramREN", 32'(ramREN), 0);
        step();
        ramready = 1'b0;
        chk("idr_state", 32'(arb_state), 32'(ARB_IDLE));
        chk("idr_cnt", 32'(dut.starve_cnt), 1);

        // ---- read+write together: write wins; completion without fetch clears counter ----
        dREN = 1'b1; dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF;
        step();
        chk("ww_ramWEN", 32'(ramWEN), 1);
        chk("ww_ramREN", 32'(ramREN), 0);
        chk("ww_ramstore", ramstore, 32'hDEADBEEF);
        chk("ww_ramaddr", ramaddr, 32'h100);
        ramready = 1'b1;
        step();
        ramready = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        #1;
        chk("ww_cnt_clr", 32'(dut.starve_cnt), 0);
        chk("ww_idle", 32'(arb_state), 32'(ARB_IDLE));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // hard time limit so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: observed no finish, required finish before limit");
        $fatal(1, "timeout");
    end

endmodule
